// File: rtl/dcache_write_buffer_pkg.sv
// Shared widths, FSM state type and line-address helper for the data-cache
// posted write buffer.
package dcache_wb_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 5;
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    MEM_RD = 3'd2,
    DRAIN  = 3'd3,
    GAP    = 3'd4
  } state_t;

  function automatic logic [TAG_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Line-wide enable/write/ack request bus; master issues requests, slave acks.
interface dcache_write_buffer_if #(
  parameter int unsigned ADDR_W = dcache_wb_pkg::ADDR_W,
  parameter int unsigned LINE_W = dcache_wb_pkg::LINE_W
);
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              enable;
  logic              write;
  logic              ack;

  modport master (output addr, wdata, enable, write, input rdata, ack);
  modport slave  (input addr, wdata, enable, write, output rdata, ack);
endinterface

// File: rtl/dcache_write_buffer_entry_array.sv
// Line FIFO storage for the write buffer: valid/tag/data per entry, FIFO push/pop,
// in-place data update of the matching entry and a one-hot tag match.
module wb_entry_array #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned TAG_W  = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic [LINE_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     upd,
  input  logic [LINE_W-1:0]        upd_data,
  input  logic [TAG_W-1:0]         lookup_tag,
  output logic [DEPTH-1:0]         match,
  output logic                     hit,
  output logic [LINE_W-1:0]        hit_data,
  output logic [TAG_W-1:0]         head_tag,
  output logic [LINE_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tags [DEPTH];
  logic [LINE_W-1:0] data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  always_comb begin
    match    = '0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (tags[i] == lookup_tag);
      if (match[i]) hit_data = hit_data | data[i];
    end
  end

  assign hit       = |match;
  assign head_tag  = tags[head];
  assign head_data = data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload needs no reset: an entry is only visible through its valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail] <= push_tag;
      data[tail] <= push_data;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (upd && match[i]) data[i] <= upd_data;
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the data cache and data memory: coalescing line
// FIFO, read hits served locally, misses forwarded, idle-time drain to memory.
module dcache_write_buffer
  import dcache_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LINE_W = dcache_wb_pkg::LINE_W,
  parameter int unsigned ADDR_W = dcache_wb_pkg::ADDR_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  dcache_write_buffer_if.slave    cache,
  dcache_write_buffer_if.master   mem,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned TAG_BITS = ADDR_W - OFFSET_W;

  state_t              state;
  logic [TAG_BITS-1:0] req_tag;
  logic [DEPTH-1:0]    match;
  logic                hit;
  logic [LINE_W-1:0]   hit_data;
  logic [TAG_BITS-1:0] head_tag;
  logic [LINE_W-1:0]   head_data;
  logic                full;
  logic                idle_req;
  logic                wr_hit;
  logic                wr_push;
  logic                rd_hit;
  logic                rd_miss;
  logic                drain_done;

  assign req_tag    = line_addr(cache.addr);
  assign full       = (count_o == CNT_W'(DEPTH));
  assign idle_req   = (state == IDLE) && cache.enable;
  assign wr_hit     = idle_req &&  cache.write &&  hit;
  assign wr_push    = idle_req &&  cache.write && !hit && !full;
  assign rd_hit     = idle_req && !cache.write &&  hit;
  assign rd_miss    = idle_req && !cache.write && !hit;
  assign drain_done = (state == DRAIN) && mem.ack;

  wb_entry_array #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .TAG_W  (TAG_BITS)
  ) u_entries (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (wr_push),
    .push_tag   (req_tag),
    .push_data  (cache.wdata),
    .pop        (drain_done),
    .upd        (wr_hit),
    .upd_data   (cache.wdata),
    .lookup_tag (req_tag),
    .match      (match),
    .hit        (hit),
    .hit_data   (hit_data),
    .head_tag   (head_tag),
    .head_data  (head_data),
    .count      (count_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cache.ack   <= 1'b0;
      cache.rdata <= '0;
      mem.addr    <= '0;
      mem.wdata   <= '0;
      mem.enable  <= 1'b0;
      mem.write   <= 1'b0;
    end else begin
      cache.ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_hit || wr_push) begin
            cache.ack <= 1'b1;
            state     <= ACK;
          end else if (rd_hit) begin
            cache.rdata <= hit_data;
            cache.ack   <= 1'b1;
            state       <= ACK;
          end else if (rd_miss) begin
            mem.addr   <= cache.addr;
            mem.write  <= 1'b0;
            mem.enable <= 1'b1;
            state      <= MEM_RD;
          end else if (count_o != '0) begin
            // Also reached by a write while full: drain one line, then retry it.
            mem.addr   <= {head_tag, {OFFSET_W{1'b0}}};
            mem.wdata  <= head_data;
            mem.write  <= 1'b1;
            mem.enable <= 1'b1;
            state      <= DRAIN;
          end
        end
        ACK:    state <= IDLE;
        MEM_RD: begin
          if (mem.ack) begin
            cache.rdata <= mem.rdata;
            mem.enable  <= 1'b0;
            cache.ack   <= 1'b1;
            state       <= ACK;
          end
        end
        DRAIN: begin
          if (mem.ack) begin
            mem.enable <= 1'b0;
            mem.write  <= 1'b0;
            state      <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Randomised scoreboard bench for dcache_write_buffer: a flat logical-memory and
// FIFO-of-lines model predicts read data, occupancy and the memory write order.
module tb_dcache_write_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;

  always #5 clk = ~clk;

  dcache_write_buffer_if cache_bus ();
  dcache_write_buffer_if mem_bus ();

  dcache_write_buffer #(.DEPTH(4), .LINE_W(256), .ADDR_W(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .cache   (cache_bus),
    .mem     (mem_bus),
    .count_o (count)
  );

  typedef struct {
    bit           wr;
    int unsigned  line;
    logic [255:0] data;
  } sb_t;

  sb_t          sb_q[$];
  logic [255:0] memory  [int unsigned];
  logic [255:0] logical [int unsigned];
  int unsigned  fifo_line[$];
  logic [255:0] fifo_data[$];

  int total = 0;
  int bad   = 0;
  int mem_writes = 0;
  int mem_reads  = 0;
  int mem_lat_min = 1;
  int mem_lat_max = 1;
  bit mem_busy = 0;
  bit just_acked = 0;

  function automatic logic [255:0] preload(input int unsigned line);
    logic [31:0] w;
    w = (line * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    return {8{w}};
  endfunction

  function automatic logic [255:0] mem_get(input int unsigned line);
    return memory.exists(line) ? memory[line] : preload(line);
  endfunction

  function automatic logic [255:0] logical_get(input int unsigned line);
    return logical.exists(line) ? logical[line] : preload(line);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory responder: random latency, checks the hold/gap handshake and the drain order.
  initial begin
    int          wcnt;
    bit          bw;
    logic [31:0] baddr;
    int unsigned ln;
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = '0;
    wcnt = 0; bw = 0; baddr = '0;
    forever begin
      @(negedge clk);
      mem_bus.ack = 1'b0;
      if (rst) begin
        mem_busy = 0;
        just_acked = 0;
        continue;
      end
      if (just_acked) check("mem_gap", {255'd0, mem_bus.enable}, '0);
      just_acked = 0;
      if (mem_busy) begin
        check("mem_hold", {222'd0, mem_bus.enable, mem_bus.write, mem_bus.addr},
              {222'd0, 1'b1, bw, baddr});
      end else if (mem_bus.enable) begin
        mem_busy = 1;
        bw       = mem_bus.write;
        baddr    = mem_bus.addr;
        wcnt     = $urandom_range(mem_lat_max, mem_lat_min);
      end
      if (mem_busy) begin
        if (wcnt == 0) begin
          ln = baddr[31:5];
          if (bw) begin
            total++;
            if (fifo_line.size() == 0) begin
              bad++;
              $display("FAIL drain_unexpected: actual addr=%0h required=no write", baddr);
            end else begin
              check("drain_addr", {224'd0, baddr}, {224'd0, fifo_line[0], 5'd0});
              check("drain_data", mem_bus.wdata, fifo_data[0]);
              void'(fifo_line.pop_front());
              void'(fifo_data.pop_front());
            end
            memory[ln] = mem_bus.wdata;
            mem_writes++;
          end else begin
            mem_bus.rdata = mem_get(ln);
            mem_reads++;
          end
          mem_bus.ack = 1'b1;
          mem_busy    = 0;
          just_acked  = 1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Cache-side monitor: pops the scoreboard on every ack pulse.
  initial begin
    bit  prev_ack;
    sb_t e;
    int  idx;
    prev_ack = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = 0;
        continue;
      end
      if (cache_bus.ack) begin
        check("ack_single_pulse", {255'd0, prev_ack}, '0);
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL ack_expected: actual=ack with no request required=no ack");
        end else begin
          e = sb_q.pop_front();
          if (e.wr) begin
            idx = -1;
            foreach (fifo_line[i]) if (fifo_line[i] == e.line) idx = i;
            if (idx >= 0) fifo_data[idx] = e.data;
            else begin
              fifo_line.push_back(e.line);
              fifo_data.push_back(e.data);
            end
          end else begin
            check("read_data", cache_bus.rdata, e.data);
          end
          check("count_after_ack", {253'd0, count}, 256'(fifo_line.size()));
        end
      end
      prev_ack = cache_bus.ack;
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                       input bit hold_late, output int cyc);
    sb_t e;
    e.wr   = wr;
    e.line = addr[31:5];
    if (wr) begin
      logical[e.line] = data;
      e.data = data;
    end else begin
      e.data = logical_get(e.line);
    end
    sb_q.push_back(e);
    cache_bus.addr   = addr;
    cache_bus.wdata  = data;
    cache_bus.write  = wr;
    cache_bus.enable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cache_bus.ack && cyc < 300);
    if (!cache_bus.ack) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: actual=no ack after %0d cycles required=ack addr=%0h", cyc, addr);
    end
    if (hold_late) begin
      @(posedge clk);
      #1;
    end
    cache_bus.enable = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    mem_busy = 0;
    just_acked = 0;
    mem_bus.ack = 1'b0;
    sb_q.delete();
    fifo_line.delete();
    fifo_data.delete();
    logical.delete();
    foreach (memory[k]) logical[k] = memory[k];
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain_all();
    for (int n = 0; n < 400; n++) begin
      if (fifo_line.size() == 0 && !mem_bus.enable && !mem_busy) break;
      @(negedge clk);
    end
    check("drain_empty", {253'd0, count}, '0);
  endtask

  initial begin
    int           cyc;
    int           w0;
    int           r0;
    logic [255:0] d [5];
    logic [255:0] x;
    logic [255:0] y;
    int unsigned  ln;
    bit           wr;
    rst = 1'b1;
    cache_bus.enable = 1'b0;
    cache_bus.write  = 1'b0;
    cache_bus.addr   = '0;
    cache_bus.wdata  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_count",  {253'd0, count}, '0);
    check("rst_ack",    {255'd0, cache_bus.ack}, '0);
    check("rst_rdata",  cache_bus.rdata, '0);
    check("rst_mem_ctl", {254'd0, mem_bus.enable, mem_bus.write}, '0);
    check("rst_mem_addr", {224'd0, mem_bus.addr}, '0);
    check("rst_mem_wdata", mem_bus.wdata, '0);

    // Write then read-hit the same line.
    mem_lat_min = 1; mem_lat_max = 1;
    r0 = mem_reads;
    issue(1, 32'h0400, {32{8'hA5}}, 0, cyc);
    check("write_latency", 256'(cyc), 256'd1);
    issue(0, 32'h0400, '0, 0, cyc);
    check("hit_latency", 256'(cyc), 256'd2);
    check("hit_no_mem_read", 256'(mem_reads - r0), '0);
    drain_all();

    // Fill, then a fifth write must wait for one drain.
    mem_lat_min = 2; mem_lat_max = 2;
    reset_dut();
    w0 = mem_writes;
    for (int i = 0; i < 5; i++) d[i] = rand_line();
    for (int i = 0; i < 4; i++) issue(1, 32'(i * 32), d[i], 0, cyc);
    issue(1, 32'h0080, d[4], 0, cyc);
    check("full_stall", {255'd0, cyc > 2}, 256'd1);
    check("full_one_drain", 256'(mem_writes - w0), 256'd1);
    drain_all();
    check("full_drains", 256'(mem_writes - w0), 256'd5);
    for (int i = 0; i < 5; i++) check("full_mem", mem_get(i), d[i]);

    // Coalescing two writes to one line.
    reset_dut();
    w0 = mem_writes;
    x = rand_line();
    y = rand_line();
    issue(1, 32'h0020, x, 0, cyc);
    issue(1, 32'h0020, y, 0, cyc);
    check("coalesce_count", {253'd0, count}, 256'd1);
    drain_all();
    check("coalesce_writes", 256'(mem_writes - w0), 256'd1);
    check("coalesce_mem", mem_get(1), y);

    // Read miss to a preloaded line.
    memory[7] = 256'h5;
    mem_lat_min = 3; mem_lat_max = 3;
    reset_dut();
    r0 = mem_reads;
    issue(0, 32'h00E0, '0, 0, cyc);
    check("miss_mem_reads", 256'(mem_reads - r0), 256'd1);
    check("miss_count", {253'd0, count}, '0);

    // Reset while draining three buffered lines.
    mem_lat_min = 6; mem_lat_max = 6;
    reset_dut();
    for (int i = 1; i <= 3; i++) issue(1, 32'(i * 32), rand_line(), 0, cyc);
    cyc = 0;
    while (!(mem_bus.enable && mem_bus.write) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_rst_drain", {255'd0, mem_bus.enable && mem_bus.write}, 256'd1);
    check("pre_rst_count", {253'd0, count}, 256'd3);
    @(negedge clk);
    reset_dut();
    check("post_rst_count", {253'd0, count}, '0);
    check("post_rst_mem_en", {255'd0, mem_bus.enable}, '0);
    check("post_rst_ack", {255'd0, cache_bus.ack}, '0);
    mem_lat_min = 1; mem_lat_max = 1;
    issue(0, 32'h0020, '0, 0, cyc);
    drain_all();

    // Enable held through the ack cycle must not re-push.
    reset_dut();
    w0 = mem_writes;
    issue(1, 32'h0100, rand_line(), 1, cyc);
    @(negedge clk);
    check("hold_count", {253'd0, count}, 256'd1);
    drain_all();
    check("hold_writes", 256'(mem_writes - w0), 256'd1);

    // Randomised mix over eight lines.
    mem_lat_min = 0; mem_lat_max = 3;
    for (int n = 0; n < 300; n++) begin
      ln = $urandom_range(7, 0);
      wr = ($urandom_range(9, 0) < 6);
      issue(wr, {ln[26:0], 5'd0} | 32'($urandom_range(31, 0)), rand_line(),
            1'($urandom_range(1, 0)), cyc);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    @(negedge clk);
    drain_all();
    for (int unsigned l = 0; l < 8; l++) check("final_mem", mem_get(l), logical_get(l));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Posted write buffer between the data cache's memory port and the off-chip data memory. Dirty-line write-backs from the cache are accepted into a small line FIFO and acknowledged quickly, then drained to memory when the memory port is free. Cache line reads are served from the buffer when the line is resident, otherwise forwarded to memory, so a refill never sees stale data. Both sides use the existing enable/write/ack line protocol, so the block drops in between the CPU's memory port and the data memory with no change to either.

## Interface
- DEPTH, 4, number of 256-bit line entries (power of two, ≥2)
- LINE_W, 256, line width in bits
- ADDR_W, 32, byte address width; line address = addr[31:5]

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- cache_addr_i  in  ADDR_W  request byte address from cache
- cache_data_i  in  LINE_W  write-back line data
- cache_enable_i  in  1  request valid, held until ack
- cache_write_i  in  1  1 = write-back, 0 = line read
- cache_ack_o  out  1  one-cycle completion pulse
- cache_data_o  out  LINE_W  read data, valid while cache_ack_o=1
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  LINE_W  memory write data
- mem_enable_o  out  1  memory request, held until mem_ack_i
- mem_write_o  out  1  memory write select
- mem_ack_i  in  1  memory completion pulse
- mem_data_i  in  LINE_W  memory read data, valid with mem_ack_i
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- States: IDLE, ACK, MEM_RD, DRAIN, GAP.
- IDLE, priority order:
  1. Cache write, line address matches a valid entry: overwrite that entry's data in place (coalesce, no push) -> ACK.
  2. Cache write, no match, count<DEPTH: push at tail -> ACK.
  3. Cache read, match: latch entry data to cache_data_o -> ACK.
  4. Cache read, miss: drive mem_addr_o=addr, mem_write_o=0, mem_enable_o=1 -> MEM_RD.
  5. Otherwise, including a write while full, if count>0: drive the head entry to memory, mem_write_o=1, mem_enable_o=1 -> DRAIN.
- MEM_RD: on mem_ack_i, latch mem_data_i to cache_data_o, drop mem_enable_o -> ACK.
- DRAIN: on mem_ack_i, pop head, drop mem_enable_o -> GAP.
- GAP: one idle cycle so memory sees enable low -> IDLE.
- ACK: cache_ack_o=1 for exactly this cycle. cache_enable_i is still high here and is ignored -> IDLE.
- At most one valid entry per line address, guaranteed by coalescing. Match compares addr[31:5] only.
- Requests arriving during MEM_RD, DRAIN or GAP wait. Cache holds enable until served.
- A write while full stalls until one DRAIN completes, then is accepted.

## Timing
- All outputs registered. Reset values: every output 0, count_o=0, state IDLE, all entries invalid.
- Write accept / read hit: request sampled at edge k in IDLE -> cache_ack_o high in cycle k+1.
- Read miss: mem_enable_o high from cycle k+1 until the edge sampling mem_ack_i. cache_ack_o high the cycle after that edge.
- Drain: the same memory handshake, followed by a mandatory GAP cycle.
- Head/tail pointers wrap modulo DEPTH. The full/empty distinction comes from count, not the pointers.
- Reset mid-operation (any state): buffered lines are discarded, mem_enable_o and cache_ack_o drop on the next cycle. Memory shares rst_i.

## Structure
- Package dcache_wb_pkg: LINE_W, ADDR_W, OFFSET_W=5, the state enum, and line_addr(addr) = addr[31:5].
- Sub-module wb_entry_array: valid/tag/data storage with push, pop, in-place write and a one-hot match output. The top level holds the FSM and the handshakes.

## Test plan
- Write 0x0400 (line 0xA5…A5) then read 0x0400 -> read hit, ack after 1 cycle, data 0xA5…A5. No memory read is issued before the drain.
- Four writes to lines 0x0000/0x0020/0x0040/0x0060, then a fifth to 0x0080 -> fifth ack only after one DRAIN completes. Memory ends with all five lines in FIFO order.
- Write 0x0020=X, then 0x0020=Y before it drains -> count_o stays 1 and memory receives only Y.
- Read miss 0x00E0 with memory preloaded 0x5 -> mem_enable_o/mem_write_o=0 until mem_ack_i, then cache_ack_o with data 0x5. count_o unchanged.
- Assert rst_i mid-DRAIN with count_o=3 -> next cycle count_o=0, mem_enable_o=0, state IDLE.
- Hold cache_enable_i high through ACK -> exactly one push per request, with no duplicate ack.
